stc_reduce_acc: RTL

STC_REDUCE_ACC -- requirements
Module: stc_reduce_acc

---
 rtl/stc_pkg.sv | 14 +
 rtl/stc_adder_tree.sv | 27 ++
 rtl/stc_reduce_acc.sv | 106 ++++++++++
 3 files changed

// File: rtl/stc_pkg.sv
// Shared defaults and FSM encoding for the tile reduce/accumulate block.
package stc_pkg;

  localparam int N_PE_DEF    = 4;
  localparam int N_DEF       = 16;
  localparam int DW_DATA_DEF = 32;
  localparam int DW_ACC_DEF  = 32;
  localparam int CNT_W_DEF   = 8;

  // Stage-2 tile state: IDLE = no tile open, RUN = tile open.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/stc_adder_tree.sv
// Combinational sum of N products into one DW_ACC-bit partial.
// Products are treated as unsigned: zero-extended when narrower than the
// accumulator, truncated when wider; the sum wraps modulo 2^DW_ACC.
module stc_adder_tree #(
  parameter int N       = 16,
  parameter int DW_DATA = 32,
  parameter int DW_ACC  = 32
) (
  input  logic [N*DW_DATA-1:0] prod,
  output logic [DW_ACC-1:0]    sum
);

  localparam int EW = (DW_DATA > DW_ACC) ? DW_DATA : DW_ACC;

  logic [EW-1:0] ext;

  // Resize every product to the accumulator width and add them up.
  always_comb begin
    sum = '0;
    ext = '0;
    for (int i = 0; i < N; i++) begin
      ext = EW'(prod[i*DW_DATA +: DW_DATA]);
      sum = sum + ext[DW_ACC-1:0];
    end
  end

endmodule

// File: rtl/stc_reduce_acc.sv
// Two-stage tile reducer: stage 1 sums each PE's N products per beat,
// stage 2 accumulates the per-PE partials across the beats of a tile and
// holds the finished tile sum until the consumer takes it.
module stc_reduce_acc #(
  parameter int N_PE    = stc_pkg::N_PE_DEF,
  parameter int N       = stc_pkg::N_DEF,
  parameter int N_UNIT  = N_PE * N,
  parameter int DW_DATA = stc_pkg::DW_DATA_DEF,
  parameter int DW_ACC  = stc_pkg::DW_ACC_DEF,
  parameter int CNT_W   = stc_pkg::CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [N_UNIT*DW_DATA-1:0] in_prod,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_PE*DW_ACC-1:0]   out_sum,
  output logic [CNT_W-1:0]         out_beats
);

  import stc_pkg::*;

  // The whole pipeline advances together; a held result freezes it.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic              s1_valid;
  logic              s1_last;
  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              tile_open;

  logic [DW_ACC-1:0] tree_sum [N_PE];
  logic [DW_ACC-1:0] partial  [N_PE];
  logic [DW_ACC-1:0] acc      [N_PE];
  logic [DW_ACC-1:0] sum_q    [N_PE];

  assign tile_open = (state == ST_RUN);

  genvar gi;
  generate
    for (gi = 0; gi < N_PE; gi++) begin : g_pe
      stc_adder_tree #(
        .N       (N),
        .DW_DATA (DW_DATA),
        .DW_ACC  (DW_ACC)
      ) u_tree (
        .prod (in_prod[gi*N*DW_DATA +: N*DW_DATA]),
        .sum  (tree_sum[gi])
      );

      assign out_sum[gi*DW_ACC +: DW_ACC] = sum_q[gi];

      // Per-PE datapath: register the partial, fold it into the tile sum.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          partial[gi] <= '0;
          acc[gi]     <= '0;
          sum_q[gi]   <= '0;
        end else if (en) begin
          partial[gi] <= tree_sum[gi];
          if (s1_valid) begin
            if (s1_last) begin
              sum_q[gi] <= tile_open ? acc[gi] + partial[gi] : partial[gi];
              acc[gi]   <= '0;
            end else begin
              acc[gi]   <= tile_open ? acc[gi] + partial[gi] : partial[gi];
            end
          end
        end
      end
    end
  endgenerate

  // Stage-1 flags, tile FSM, beat counter and result handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      state     <= ST_IDLE;
      cnt       <= '0;
      out_beats <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_last   <= in_valid && in_last;
      // A completing tile loads a fresh result; otherwise a taken result clears.
      out_valid <= s1_valid && s1_last;
      if (s1_valid) begin
        if (s1_last) begin
          out_beats <= tile_open ? cnt + CNT_W'(1) : CNT_W'(1);
          cnt       <= '0;
          state     <= ST_IDLE;
        end else begin
          cnt       <= tile_open ? cnt + CNT_W'(1) : CNT_W'(1);
          state     <= ST_RUN;
        end
      end
    end
  end

endmodule
